// File: rtl/mem_load_align.sv
// mem_load_align: sequential big-endian load-alignment unit (LB/LBU/LH/LHU/LW/LWL/LWR)
// sitting between the MEM stage and an Avalon-MM read master port.
// Optional feature: define MISALIGN_SPLIT_EN to execute misaligned LW/LH/LHU, splitting
// them into two bus beats when they cross a beat boundary; otherwise they return rsp_err.
module mem_load_align #(
  parameter int BUS_BYTES  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [31:0]            req_rt,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic [ADDR_WIDTH-1:0]  avm_address,
  output logic                   avm_read,
  output logic [BUS_BYTES-1:0]   avm_byteenable,
  input  logic [8*BUS_BYTES-1:0] avm_readdata,
  input  logic                   avm_waitrequest
);

  localparam int OFFW = $clog2(BUS_BYTES);
  localparam int BW   = 8 * BUS_BYTES;

  typedef enum logic [1:0] {IDLE, READ0, READ1, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              op_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [31:0]             rt_reg;
  logic                    split_reg;
  logic [BW-1:0]           beat0_reg, beat1_reg;

  logic                    req_err, req_split;
  logic                    accept, capture0, capture1;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [BW-1:0]           beat0_cur, beat1_cur;
  logic [7:0]              mem_bytes [2*BUS_BYTES];
  logic [OFFW:0]           off, wbase;
  logic [7:0]              m [4];
  logic [7:0]              w [4];
  logic [31:0]             result;

  // Classify the incoming request: fault conditions and whether it spans two beats
  always_comb begin
    req_err   = (req_op == 3'b111);
    req_split = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    // LH/LHU cross only from the last byte of a beat; LW from any of the last three
    if (req_op[1:0] == 2'b01)
      req_split = (req_addr[OFFW-1:0] == OFFW'(BUS_BYTES - 1));
    else if (req_op == 3'b011)
      req_split = (req_addr[OFFW-1:0] > OFFW'(BUS_BYTES - 4));
`else
    if ((req_op[1:0] == 2'b01) && req_addr[0])
      req_err = 1'b1;
    if ((req_op == 3'b011) && (req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  assign beat_addr = {addr_reg[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};

  // State register; reset abandons any access in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic and bus/handshake outputs
  always_comb begin
    state_next     = state_reg;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    avm_read       = 1'b0;
    avm_address    = '0;
    avm_byteenable = '0;
    accept         = 1'b0;
    capture0       = 1'b0;
    capture1       = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = req_err ? RESP : READ0;
        end
      end
      READ0: begin
        avm_read       = 1'b1;
        avm_address    = beat_addr;
        avm_byteenable = '1;
        if (!avm_waitrequest) begin
          capture0   = 1'b1;
          state_next = split_reg ? READ1 : RESP;
        end
      end
      READ1: begin
        avm_read       = 1'b1;
        avm_address    = beat_addr + ADDR_WIDTH'(BUS_BYTES);
        avm_byteenable = '1;
        if (!avm_waitrequest) begin
          capture1   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Forward the beat being captured so the result can be registered in the same edge
  assign beat0_cur = capture0 ? avm_readdata : beat0_reg;
  assign beat1_cur = capture1 ? avm_readdata : beat1_reg;

  // Flatten both beats into a byte stream in ascending address order (big-endian lanes)
  genvar gi;
  generate
    for (gi = 0; gi < BUS_BYTES; gi++) begin : g_bytes
      assign mem_bytes[gi]             = beat0_cur[BW-1-8*gi -: 8];
      assign mem_bytes[BUS_BYTES + gi] = beat1_cur[BW-1-8*gi -: 8];
    end
  endgenerate

  assign off   = {1'b0, addr_reg[OFFW-1:0]};
  assign wbase = off & ~((OFFW+1)'(3));

  // Extract, extend or merge the addressed bytes into the register write value
  always_comb begin
    result = '0;
    for (int k = 0; k < 4; k++) begin
      m[k] = mem_bytes[off + (OFFW+1)'(k)];
      w[k] = mem_bytes[wbase + (OFFW+1)'(k)];
    end
    case (op_reg)
      3'b000: result = {{24{m[0][7]}}, m[0]};
      3'b100: result = {24'h0, m[0]};
      3'b001: result = {{16{m[0][7]}}, m[0], m[1]};
      3'b101: result = {16'h0, m[0], m[1]};
      3'b011: result = {m[0], m[1], m[2], m[3]};
      3'b010: begin
        case (addr_reg[1:0])
          2'd0:    result = {w[0], w[1], w[2], w[3]};
          2'd1:    result = {w[1], w[2], w[3], rt_reg[7:0]};
          2'd2:    result = {w[2], w[3], rt_reg[15:0]};
          default: result = {w[3], rt_reg[23:0]};
        endcase
      end
      3'b110: begin
        case (addr_reg[1:0])
          2'd0:    result = {rt_reg[31:8], w[0]};
          2'd1:    result = {rt_reg[31:16], w[0], w[1]};
          2'd2:    result = {rt_reg[31:24], w[0], w[1], w[2]};
          default: result = {w[0], w[1], w[2], w[3]};
        endcase
      end
      default: result = '0;
    endcase
  end

  // Request latch, beat capture and held response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg    <= '0;
      addr_reg  <= '0;
      rt_reg    <= '0;
      split_reg <= 1'b0;
      beat0_reg <= '0;
      beat1_reg <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        op_reg    <= req_op;
        addr_reg  <= req_addr;
        rt_reg    <= req_rt;
        split_reg <= req_split;
        if (req_err) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (capture0) beat0_reg <= avm_readdata;
      if (capture1) beat1_reg <= avm_readdata;
      if ((capture0 && !split_reg) || capture1) begin
        rsp_data <= result;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_load_align.sv
// Directed, table-driven bench for mem_load_align (BUS_BYTES=4). Expected results for
// misaligned LW/LH/LHU follow the MISALIGN_SPLIT_EN setting of the build.
module tb_mem_load_align;

  localparam logic [31:0] NOADDR = 32'hFFFF_FFFF;
  localparam int NV = 19;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_rt;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_load_align #(.BUS_BYTES(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_rt(req_rt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] w0;
    logic [31:0] w1;
    int          waits;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_rcyc;
    logic [31:0] exp_addr0;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one load and act as the memory: the beat at addr&~3 returns w0, others w1
  task automatic run_load(input vec_t v, output logic [31:0] data, output logic err,
                          output int lat, output int rcyc, output logic [31:0] addr0,
                          output bit hold_ok, output bit done);
    int wcnt;
    logic [31:0] prev_addr;
    bit prev_wait;
    wcnt = v.waits; rcyc = 0; addr0 = NOADDR; hold_ok = 1; done = 0; lat = 0;
    data = '0; err = 1'b0; prev_wait = 0; prev_addr = '0;
    @(negedge clk);
    if (!req_ready) hold_ok = 0;
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_rt = v.rt;
    @(negedge clk);
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_rt = '0;
    for (int c = 1; c <= 20 && !done; c++) begin
      if (rsp_valid) begin
        data = rsp_data; err = rsp_err; lat = c; done = 1;
        avm_waitrequest = 1'b0;
      end else begin
        if (avm_read) begin
          if (rcyc == 0) addr0 = avm_address;
          if (prev_wait && (avm_address !== prev_addr)) hold_ok = 0;
          if (avm_byteenable !== 4'hF) hold_ok = 0;
          rcyc++;
          avm_readdata    = (avm_address == (v.addr & ~32'h3)) ? v.w0 : v.w1;
          avm_waitrequest = (wcnt > 0);
          if (wcnt > 0) wcnt--;
          prev_addr = avm_address;
          prev_wait = avm_waitrequest;
        end else begin
          avm_waitrequest = 1'b0;
          prev_wait = 0;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [31:0] d, a0;
    logic e;
    int lat, rcyc, seen;
    bit hold_ok, done;

    // op, addr, rt, w0, w1, waits, exp_data, exp_err, exp_lat, exp_rcyc, exp_addr0
    vecs[0]  = '{3'b011, 32'h100, 32'h0, 32'h11223344, 32'h0, 0, 32'h11223344, 1'b0, 2, 1, 32'h100};
    vecs[1]  = '{3'b000, 32'h103, 32'h0, 32'h112233F4, 32'h0, 0, 32'hFFFFFFF4, 1'b0, 2, 1, 32'h100};
    vecs[2]  = '{3'b100, 32'h103, 32'h0, 32'h112233F4, 32'h0, 0, 32'h000000F4, 1'b0, 2, 1, 32'h100};
    vecs[3]  = '{3'b101, 32'h102, 32'h0, 32'h112233F4, 32'h0, 0, 32'h000033F4, 1'b0, 2, 1, 32'h100};
    vecs[4]  = '{3'b001, 32'h100, 32'h0, 32'h80017F00, 32'h0, 0, 32'hFFFF8001, 1'b0, 2, 1, 32'h100};
    vecs[5]  = '{3'b001, 32'h102, 32'h0, 32'h80017F00, 32'h0, 0, 32'h00007F00, 1'b0, 2, 1, 32'h100};
    vecs[6]  = '{3'b000, 32'h100, 32'h0, 32'h7FAA0000, 32'h0, 0, 32'h0000007F, 1'b0, 2, 1, 32'h100};
    vecs[7]  = '{3'b010, 32'h101, 32'h01020304, 32'hAABBCCDD, 32'h0, 0, 32'hBBCCDD04, 1'b0, 2, 1, 32'h100};
    vecs[8]  = '{3'b110, 32'h101, 32'h01020304, 32'hAABBCCDD, 32'h0, 0, 32'h0102AABB, 1'b0, 2, 1, 32'h100};
    vecs[9]  = '{3'b010, 32'h100, 32'h01020304, 32'hAABBCCDD, 32'h0, 0, 32'hAABBCCDD, 1'b0, 2, 1, 32'h100};
    vecs[10] = '{3'b110, 32'h103, 32'h01020304, 32'hAABBCCDD, 32'h0, 0, 32'hAABBCCDD, 1'b0, 2, 1, 32'h100};
    vecs[11] = '{3'b010, 32'h103, 32'h01020304, 32'hAABBCCDD, 32'h0, 0, 32'hDD020304, 1'b0, 2, 1, 32'h100};
    vecs[12] = '{3'b011, 32'h104, 32'h0, 32'hCAFEF00D, 32'h0, 3, 32'hCAFEF00D, 1'b0, 5, 4, 32'h104};
    vecs[13] = '{3'b111, 32'h100, 32'h0, 32'h12345678, 32'h0, 0, 32'h0, 1'b1, 1, 0, NOADDR};
`ifdef MISALIGN_SPLIT_EN
    vecs[14] = '{3'b001, 32'h101, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 32'hFFFFBBCC, 1'b0, 2, 1, 32'h100};
    vecs[15] = '{3'b011, 32'h102, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 32'hCCDD1122, 1'b0, 3, 2, 32'h100};
    vecs[16] = '{3'b101, 32'h103, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 32'h0000DD11, 1'b0, 3, 2, 32'h100};
    vecs[17] = '{3'b011, 32'h101, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 32'hBBCCDD11, 1'b0, 3, 2, 32'h100};
`else
    vecs[14] = '{3'b001, 32'h101, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 32'h0, 1'b1, 1, 0, NOADDR};
    vecs[15] = '{3'b011, 32'h102, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 32'h0, 1'b1, 1, 0, NOADDR};
    vecs[16] = '{3'b101, 32'h103, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 32'h0, 1'b1, 1, 0, NOADDR};
    vecs[17] = '{3'b011, 32'h101, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 32'h0, 1'b1, 1, 0, NOADDR};
`endif
    vecs[18] = '{3'b110, 32'h100, 32'h01020304, 32'hAABBCCDD, 32'h0, 0, 32'h010203AA, 1'b0, 2, 1, 32'h100};

    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_rt = '0;
    avm_readdata = '0; avm_waitrequest = 1'b0;

    // Reset state
    #3;
    check("reset req_ready", {31'b0, req_ready}, 32'h1);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset rsp_data", rsp_data, 32'h0);
    check("reset rsp_err", {31'b0, rsp_err}, 32'h0);
    check("reset avm_read", {31'b0, avm_read}, 32'h0);
    check("reset avm_address", avm_address, 32'h0);
    check("reset avm_byteenable", {28'b0, avm_byteenable}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Table-driven loads
    for (int i = 0; i < NV; i++) begin
      run_load(vecs[i], d, e, lat, rcyc, a0, hold_ok, done);
      $display("vec %0d op=%b addr=%h -> data=%h err=%b lat=%0d rd_cycles=%0d",
               i, vecs[i].op, vecs[i].addr, d, e, lat, rcyc);
      check($sformatf("vec%0d done", i), {31'b0, done}, 32'h1);
      if (done) begin
        check($sformatf("vec%0d data", i), d, vecs[i].exp_data);
        check($sformatf("vec%0d err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
        check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
        check($sformatf("vec%0d read_cycles", i), rcyc, vecs[i].exp_rcyc);
        check($sformatf("vec%0d first_addr", i), a0, vecs[i].exp_addr0);
        check($sformatf("vec%0d bus_hold", i), {31'b0, hold_ok}, 32'h1);
      end
    end

    // Response is a single-cycle pulse while data stays held
    repeat (3) @(negedge clk);
    check("hold rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("hold rsp_data", rsp_data, vecs[NV-1].exp_data);
    check("hold req_ready", {31'b0, req_ready}, 32'h1);
    $display("hold check: rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);

    // Reset asserted while READ0 is stalled by waitrequest
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b011; req_addr = 32'h200; req_rt = '0;
    avm_waitrequest = 1'b1; avm_readdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    check("midread avm_read", {31'b0, avm_read}, 32'h1);
    check("midread avm_address", avm_address, 32'h200);
    check("midread req_ready", {31'b0, req_ready}, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    check("async rst avm_read", {31'b0, avm_read}, 32'h0);
    check("async rst req_ready", {31'b0, req_ready}, 32'h1);
    check("async rst rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("async rst avm_address", avm_address, 32'h0);
    check("async rst rsp_data", rsp_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1; avm_waitrequest = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid || avm_read) seen++;
    end
    check("post reset no activity", seen, 0);
    $display("reset during READ0: avm_read=%b req_ready=%b activity=%0d", avm_read, req_ready, seen);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
